// File: rtl/d_sc_parallel_lfs_divider_pkg.sv
// Shared constants for the parallel LFSR divider: default field order, the BCH minimal
// polynomial of this code and the FSM state encoding.
package d_sc_parallel_lfs_divider_pkg;

  localparam int GF_ORDER_DEF = 12;
  localparam int PARALLEL_DEF = 8;
  localparam int NUM_POLY_DEF = 2;
  localparam int CW_CHUNKS_DEF = 1024;

  // x^12 + x^6 + x^4 + x + 1
  localparam logic [GF_ORDER_DEF:0] MIN_POLY_1053 = 13'h1053;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/d_sc_parallel_lfs_divider_if.sv
// Stream-in / remainders-out handshake bundle of the parallel LFSR divider.
// The zero-flag outputs exist only when D_SC_LFS_ZERO_FLAG_EN is defined.
interface d_sc_parallel_lfs_divider_if
  import d_sc_parallel_lfs_divider_pkg::*;
#(
  parameter int GF_ORDER = GF_ORDER_DEF,
  parameter int PARALLEL = PARALLEL_DEF,
  parameter int NUM_POLY = NUM_POLY_DEF
);
  logic                         i_start;
  logic                         i_data_valid;
  logic                         o_data_ready;
  logic [PARALLEL-1:0]          i_data;
  logic                         o_rem_valid;
  logic                         i_rem_ready;
  logic [NUM_POLY*GF_ORDER-1:0] o_remainders;
  logic                         o_busy;
`ifdef D_SC_LFS_ZERO_FLAG_EN
  logic [NUM_POLY-1:0]          o_rem_zero;
  logic                         o_all_zero;
`endif

  modport master (
    output i_start, i_data_valid, i_data, i_rem_ready,
`ifdef D_SC_LFS_ZERO_FLAG_EN
    input  o_rem_zero, o_all_zero,
`endif
    input  o_data_ready, o_rem_valid, o_remainders, o_busy
  );

  modport slave (
    input  i_start, i_data_valid, i_data, i_rem_ready,
`ifdef D_SC_LFS_ZERO_FLAG_EN
    output o_rem_zero, o_all_zero,
`endif
    output o_data_ready, o_rem_valid, o_remainders, o_busy
  );

endinterface

// File: rtl/d_sc_lfs_step_p.sv
// Combinational PARALLEL-step unroll of one serial LFSR divider: feeds the beat MSB first
// into the remainder r, reducing modulo the minimal polynomial (implicit leading x^m).
module d_sc_lfs_step_p
  import d_sc_parallel_lfs_divider_pkg::*;
#(
  parameter int GF_ORDER = GF_ORDER_DEF,
  parameter int PARALLEL = PARALLEL_DEF
) (
  input  logic [GF_ORDER-1:0] r_in,
  input  logic [PARALLEL-1:0] data,
  input  logic [GF_ORDER-1:0] poly,
  output logic [GF_ORDER-1:0] r_out
);

  logic [GF_ORDER-1:0] acc;
  logic                fb;

  always_comb begin
    acc = r_in;
    fb  = 1'b0;
    for (int i = PARALLEL - 1; i >= 0; i--) begin
      fb     = acc[GF_ORDER-1];
      acc    = {acc[GF_ORDER-2:0], 1'b0} ^ (fb ? poly : '0);
      acc[0] = acc[0] ^ data[i];
    end
    r_out = acc;
  end

endmodule

// File: rtl/d_sc_parallel_lfs_divider.sv
// Multi-channel P-bit-parallel polynomial divider feeding the BCH syndrome evaluator.
// Optional zero-detect flags are built when D_SC_LFS_ZERO_FLAG_EN is defined.
module d_sc_parallel_lfs_divider
  import d_sc_parallel_lfs_divider_pkg::*;
#(
  parameter int GF_ORDER  = GF_ORDER_DEF,
  parameter int PARALLEL  = PARALLEL_DEF,
  parameter int NUM_POLY  = NUM_POLY_DEF,
  parameter int CW_CHUNKS = CW_CHUNKS_DEF,
  parameter logic [NUM_POLY*(GF_ORDER+1)-1:0] MIN_POLY_VEC = {NUM_POLY{MIN_POLY_1053}}
) (
  input logic                        i_clk,
  input logic                        i_nRESET,
  d_sc_parallel_lfs_divider_if.slave bus
);

  localparam int CNT_W = $clog2(CW_CHUNKS + 1);
  localparam int REM_W = NUM_POLY * GF_ORDER;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [REM_W-1:0]   step_r;
  logic               accept;
  logic               last_beat;

  // One unrolled divider per minimal polynomial; x^m coefficient is implicit.
  for (genvar k = 0; k < NUM_POLY; k++) begin : g_chan
    d_sc_lfs_step_p #(
      .GF_ORDER (GF_ORDER),
      .PARALLEL (PARALLEL)
    ) u_step (
      .r_in  (rem_q[k*GF_ORDER +: GF_ORDER]),
      .data  (bus.i_data),
      .poly  (MIN_POLY_VEC[k*(GF_ORDER+1) +: GF_ORDER]),
      .r_out (step_r[k*GF_ORDER +: GF_ORDER])
    );
  end

  assign accept    = (state_q == ST_RUN) && bus.i_data_valid;
  assign last_beat = (cnt_q == CNT_W'(CW_CHUNKS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          cnt_d   = '0;
          rem_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          rem_d = step_r;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.i_rem_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.o_data_ready = (state_q == ST_RUN);
  assign bus.o_rem_valid  = (state_q == ST_DONE);
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_remainders = rem_q;

`ifdef D_SC_LFS_ZERO_FLAG_EN
  logic [NUM_POLY-1:0] rem_zero_q, rem_zero_d;
  logic                all_zero_q, all_zero_d;

  // Flags are computed from the next remainders so they line up with o_rem_valid.
  always_comb begin
    rem_zero_d = '0;
    for (int k = 0; k < NUM_POLY; k++) begin
      rem_zero_d[k] = (state_d == ST_DONE) && (rem_d[k*GF_ORDER +: GF_ORDER] == '0);
    end
    all_zero_d = (state_d == ST_DONE) && (&rem_zero_d);
  end

  always_ff @(posedge i_clk or negedge i_nRESET) begin
    if (!i_nRESET) begin
      rem_zero_q <= '0;
      all_zero_q <= 1'b0;
    end else begin
      rem_zero_q <= rem_zero_d;
      all_zero_q <= all_zero_d;
    end
  end

  assign bus.o_rem_zero = rem_zero_q;
  assign bus.o_all_zero = all_zero_q;
`endif

endmodule
